// File: rtl/fir_stream_sched.sv
// Sequencer for a free-running FIR. It buffers samples in a 16-deep FIFO, pulses the FIR reset,
// then feeds data, zero-fill and a zero flush. Output tags trail fir_data_in by FIR_LAT cycles; there is no output backpressure.

module fir_sched_fifo #(
  parameter int W  = 17,
  parameter int AW = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         push,
  input  logic [W-1:0] push_dat,
  input  logic         pop,
  output logic [W-1:0] head,
  output logic         empty,
  output logic         full
);
  localparam int DEPTH = 1 << AW;

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wptr;
  logic [AW-1:0] rptr;
  logic [AW:0]   count;
  logic          do_push;
  logic          do_pop;

  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign empty   = (count == '0);
  assign full    = (count == (AW+1)'(DEPTH));
  assign head    = mem[rptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wptr] <= push_dat;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (do_push) wptr <= wptr + AW'(1);
      if (do_pop)  rptr <= rptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end
endmodule

module fir_stream_sched #(
  parameter int DW          = 16,
  parameter int FIFO_AW     = 4,
  parameter int FIR_LAT     = 1,
  parameter int FIR_RST_CYC = 3,
  parameter int FLUSH_LEN   = 32
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  output logic          busy,
  output logic          done,
  input  logic          in_valid,
  input  logic [DW-1:0] in_data,
  input  logic          in_last,
  output logic          in_ready,
  output logic          fir_reset,
  output logic [DW-1:0] fir_data_in,
  input  logic [DW-1:0] fir_data_out,
  output logic          out_valid,
  output logic [DW-1:0] out_data,
  output logic          out_last,
  output logic          underrun,
  output logic [15:0]   underrun_cnt
);
  localparam int CW = 16;

  typedef enum logic [2:0] {S_IDLE, S_RST, S_RUN, S_FLUSH, S_DRAIN} state_t;

  state_t        state;
  state_t        state_nxt;
  logic [CW-1:0] cnt;
  logic          last_seen;
  logic          fifo_push;
  logic          fifo_pop;
  logic          fifo_empty;
  logic          fifo_full;
  logic [DW:0]   fifo_head;
  logic          zero_fill;
  logic          tag_vld;
  logic          tag_last;
  logic [FIR_LAT:0] vld_sr;
  logic [FIR_LAT:0] last_sr;

  assign in_ready  = !fifo_full && !last_seen;
  assign fifo_push = in_valid && in_ready;

  fir_sched_fifo #(
    .W  (DW + 1),
    .AW (FIFO_AW)
  ) u_fifo (
    .clk      (clk),
    .reset    (reset),
    .push     (fifo_push),
    .push_dat ({in_last, in_data}),
    .pop      (fifo_pop),
    .head     (fifo_head),
    .empty    (fifo_empty),
    .full     (fifo_full)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= S_IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= (state_nxt != state || state == S_IDLE) ? '0 : cnt + CW'(1);
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (start) state_nxt = S_RST;
      S_RST:   if (cnt == CW'(FIR_RST_CYC - 1)) state_nxt = S_RUN;
      S_RUN:   if (fifo_pop && fifo_head[DW]) state_nxt = S_FLUSH;
      S_FLUSH: if (cnt == CW'(FLUSH_LEN - 1)) state_nxt = S_DRAIN;
      S_DRAIN: if (cnt == CW'(FIR_LAT - 1)) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    busy      = (state != S_IDLE);
    fir_reset = (state == S_RST);
    fifo_pop  = (state == S_RUN) && !fifo_empty;
    zero_fill = (state == S_RUN) && fifo_empty;
    tag_vld   = (state == S_RUN) || (state == S_FLUSH);
    tag_last  = (state == S_FLUSH) && (cnt == CW'(FLUSH_LEN - 1));
  end

  // Tag stage 0 lines up with fir_data_in; FIR_LAT further stages line up with fir_data_out.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      fir_data_in  <= '0;
      vld_sr       <= '0;
      last_sr      <= '0;
      done         <= 1'b0;
      last_seen    <= 1'b0;
      underrun     <= 1'b0;
      underrun_cnt <= '0;
    end else begin
      fir_data_in <= fifo_pop ? fifo_head[DW-1:0] : '0;
      vld_sr      <= {vld_sr[FIR_LAT-1:0], tag_vld};
      last_sr     <= {last_sr[FIR_LAT-1:0], tag_last};
      done        <= (state == S_DRAIN) && (state_nxt == S_IDLE);
      if (state != S_IDLE && state_nxt == S_IDLE) begin
        last_seen <= 1'b0;
      end else if (fifo_push && in_last) begin
        last_seen <= 1'b1;
      end
      if (state == S_IDLE && start) begin
        underrun     <= 1'b0;
        underrun_cnt <= '0;
      end else if (zero_fill) begin
        underrun <= 1'b1;
        if (underrun_cnt != 16'hFFFF) underrun_cnt <= underrun_cnt + 16'd1;
      end
    end
  end

  assign out_valid = vld_sr[FIR_LAT];
  assign out_last  = last_sr[FIR_LAT];
  assign out_data  = fir_data_out;
endmodule
